// File: rtl/bin_to_bcd_seq.sv
// Sequential 14-bit binary to 4-digit BCD converter (double dabble, one bit per cycle).
// Results are registered once per conversion; values above 9999 saturate to 9999 and raise overflow.
module bin_to_bcd_seq (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        start,
  input  logic [13:0] value,
  output logic        busy,
  output logic        done,
  output logic        overflow,
  output logic [3:0]  num3,
  output logic [3:0]  num2,
  output logic [3:0]  num1,
  output logic [3:0]  num0,
  output logic [3:0]  lz
);

  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

  state_t      state_reg, state_next;
  logic [13:0] bin_reg, bin_next;
  logic [15:0] bcd_reg, bcd_next;
  logic [15:0] bcd_adj;
  logic [3:0]  cnt_reg, cnt_next;
  logic        ovf_cap_reg, ovf_cap_next;
  logic [15:0] num_reg, num_next;
  logic [3:0]  lz_reg, lz_next;
  logic        overflow_reg, overflow_next;
  logic        done_reg, done_next;
  logic [15:0] res;
  logic [3:0]  res_lz;

  // Add-3 correction on every nibble before each shift
  generate
    for (genvar gi = 0; gi < 4; gi++) begin : g_adj
      assign bcd_adj[gi*4 +: 4] = (bcd_reg[gi*4 +: 4] >= 4'd5) ?
                                  bcd_reg[gi*4 +: 4] + 4'd3 : bcd_reg[gi*4 +: 4];
    end
  endgenerate

  assign res       = ovf_cap_reg ? 16'h9999 : bcd_reg;
  assign res_lz[3] = (res[15:12] == 4'd0);
  assign res_lz[2] = res_lz[3] && (res[11:8] == 4'd0);
  assign res_lz[1] = res_lz[2] && (res[7:4] == 4'd0);
  assign res_lz[0] = 1'b0;

  always_comb begin
    state_next    = state_reg;
    bin_next      = bin_reg;
    bcd_next      = bcd_reg;
    cnt_next      = cnt_reg;
    ovf_cap_next  = ovf_cap_reg;
    num_next      = num_reg;
    lz_next       = lz_reg;
    overflow_next = overflow_reg;
    done_next     = 1'b0;
    case (state_reg)
      IDLE: begin
        if (start) begin
          bin_next     = value;
          bcd_next     = 16'd0;
          cnt_next     = 4'd0;
          ovf_cap_next = (value > 14'd9999);
          state_next   = SHIFT;
        end
      end
      SHIFT: begin
        {bcd_next, bin_next} = {bcd_adj[14:0], bin_reg, 1'b0};
        cnt_next = cnt_reg + 4'd1;
        if (cnt_reg == 4'd13) state_next = DONE;
      end
      DONE: begin
        num_next      = res;
        lz_next       = res_lz;
        overflow_next = ovf_cap_reg;
        done_next     = 1'b1;
        state_next    = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_reg    <= IDLE;
      bin_reg      <= 14'd0;
      bcd_reg      <= 16'd0;
      cnt_reg      <= 4'd0;
      ovf_cap_reg  <= 1'b0;
      num_reg      <= 16'd0;
      lz_reg       <= 4'b1110;
      overflow_reg <= 1'b0;
      done_reg     <= 1'b0;
    end else begin
      state_reg    <= state_next;
      bin_reg      <= bin_next;
      bcd_reg      <= bcd_next;
      cnt_reg      <= cnt_next;
      ovf_cap_reg  <= ovf_cap_next;
      num_reg      <= num_next;
      lz_reg       <= lz_next;
      overflow_reg <= overflow_next;
      done_reg     <= done_next;
    end
  end

  assign busy     = (state_reg != IDLE);
  assign done     = done_reg;
  assign overflow = overflow_reg;
  assign num3     = num_reg[15:12];
  assign num2     = num_reg[11:8];
  assign num1     = num_reg[7:4];
  assign num0     = num_reg[3:0];
  assign lz       = lz_reg;

endmodule

// File: tb/tb_bin_to_bcd_seq.sv
// Scoreboard bench for bin_to_bcd_seq: drivers push expected results and done cycles,
// a negedge monitor pops and compares on every done pulse.
module tb_bin_to_bcd_seq;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        start;
  logic [13:0] value;
  logic        busy, done, overflow;
  logic [3:0]  num3, num2, num1, num0, lz;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  typedef struct {
    logic [15:0] num;
    logic [3:0]  lz;
    logic        ovf;
    int          cyc;
  } exp_t;

  exp_t sb[$];

  bin_to_bcd_seq dut (
    .clk(clk), .reset_n(reset_n), .start(start), .value(value),
    .busy(busy), .done(done), .overflow(overflow),
    .num3(num3), .num2(num2), .num1(num1), .num0(num0), .lz(lz)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Monitor: compares every done pulse against the oldest expectation
  always @(negedge clk) begin
    if (busy && done) begin
      errors++;
      $display("FAIL busy_done_overlap cyc=%0d busy=%b done=%b required: not both high", cyc, busy, done);
    end
    if (num3 > 4'd9 || num2 > 4'd9 || num1 > 4'd9 || num0 > 4'd9) begin
      errors++;
      $display("FAIL bcd_range cyc=%0d got %h%h%h%h", cyc, num3, num2, num1, num0);
    end
    if (done) begin
      checks++;
      if (sb.size() == 0) begin
        errors++;
        $display("FAIL unexpected_done cyc=%0d num=%h%h%h%h", cyc, num3, num2, num1, num0);
      end else begin
        exp_t e;
        e = sb.pop_front();
        if ({num3, num2, num1, num0} !== e.num || lz !== e.lz || overflow !== e.ovf || cyc != e.cyc) begin
          errors++;
          $display("FAIL result cyc=%0d got num=%h%h%h%h lz=%b ovf=%b, required num=%h lz=%b ovf=%b cyc=%0d",
                   cyc, num3, num2, num1, num0, lz, overflow, e.num, e.lz, e.ovf, e.cyc);
        end else begin
          $display("done cyc=%0d num=%h%h%h%h lz=%b ovf=%b ok", cyc, num3, num2, num1, num0, lz, overflow);
        end
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s got %h required %h", name, act, req);
    end else begin
      $display("check %s = %h ok", name, act);
    end
  endtask

  task automatic chk_reset_state(input string name);
    chk({name, "_busy"}, {31'd0, busy}, 32'd0);
    chk({name, "_done"}, {31'd0, done}, 32'd0);
    chk({name, "_num"}, {16'd0, num3, num2, num1, num0}, 32'h0000);
    chk({name, "_lz"}, {28'd0, lz}, 32'b1110);
    chk({name, "_ovf"}, {31'd0, overflow}, 32'd0);
  endtask

  task automatic push(input logic [15:0] n, input logic [3:0] l, input logic o, input int c);
    exp_t e;
    e.num = n; e.lz = l; e.ovf = o; e.cyc = c;
    sb.push_back(e);
  endtask

  // Issue one start pulse and expect the result 15 edges after acceptance
  task automatic convert(input logic [13:0] v, input logic [15:0] n, input logic [3:0] l, input logic o);
    @(negedge clk);
    start = 1'b1;
    value = v;
    @(posedge clk); #1;
    push(n, l, o, cyc + 15);
    $display("start value=%0d at cyc=%0d", v, cyc);
    @(negedge clk);
    start = 1'b0;
    repeat (17) @(negedge clk);
  endtask

  initial begin
    int n0;
    reset_n = 1'b0;
    start   = 1'b0;
    value   = 14'd0;
    repeat (2) @(posedge clk);
    // start coinciding with reset must be dropped
    @(negedge clk);
    start = 1'b1;
    value = 14'd1234;
    @(posedge clk); #1;
    chk_reset_state("reset");
    @(negedge clk);
    start   = 1'b0;
    reset_n = 1'b1;
    @(negedge clk);
    chk("idle_after_reset_busy", {31'd0, busy}, 32'd0);

    // Nominal conversion with busy window checks
    @(negedge clk);
    start = 1'b1;
    value = 14'd1234;
    @(posedge clk); #1;
    n0 = cyc;
    push(16'h1234, 4'b0000, 1'b0, n0 + 15);
    chk("busy_after_e0", {31'd0, busy}, 32'd1);
    @(negedge clk);
    start = 1'b0;
    repeat (14) @(negedge clk);
    chk("busy_at_e14", {31'd0, busy}, 32'd1);
    chk("done_low_at_e14", {31'd0, done}, 32'd0);
    @(negedge clk);
    chk("busy_low_at_e15", {31'd0, busy}, 32'd0);
    repeat (2) @(negedge clk);

    convert(14'd0,     16'h0000, 4'b1110, 1'b0);
    convert(14'd7,     16'h0007, 4'b1110, 1'b0);
    convert(14'd305,   16'h0305, 4'b1000, 1'b0);
    convert(14'd9999,  16'h9999, 4'b0000, 1'b0);
    convert(14'd10000, 16'h9999, 4'b0000, 1'b1);
    convert(14'd16383, 16'h9999, 4'b0000, 1'b1);

    // start held for 20 edges, value changes at E3
    @(negedge clk);
    start = 1'b1;
    value = 14'd1234;
    @(posedge clk); #1;
    n0 = cyc;
    push(16'h1234, 4'b0000, 1'b0, n0 + 15);
    push(16'h5678, 4'b0000, 1'b0, n0 + 31);
    repeat (3) @(negedge clk);
    value = 14'd5678;
    while (cyc < n0 + 19) @(negedge clk);
    start = 1'b0;
    repeat (15) @(negedge clk);

    // Reset at E7 of a conversion of 4321
    @(negedge clk);
    start = 1'b1;
    value = 14'd4321;
    @(posedge clk); #1;
    @(negedge clk);
    start = 1'b0;
    repeat (6) @(negedge clk);
    reset_n = 1'b0;
    @(posedge clk); #1;
    chk_reset_state("midreset");
    @(negedge clk);
    reset_n = 1'b1;
    repeat (20) @(negedge clk);
    convert(14'd42, 16'h0042, 4'b1100, 1'b0);

    repeat (4) @(negedge clk);
    chk("scoreboard_empty", sb.size(), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/bin_to_bcd_seq.md
BIN_TO_BCD_SEQ -- requirements
Module: bin_to_bcd_seq

Interface
REQ-001 The block SHALL have one clock and a synchronous, active-low reset: `clk` (input, 1, rising-edge clock) and `reset_n` (input, 1, synchronous reset, active low).
REQ-002 The block SHALL have port `start`: input, 1 bit, conversion request; sampled on the rising edge of `clk`.
REQ-003 The block SHALL have port `value`: input, 14 bits, unsigned binary operand; captured on the edge that accepts `start`.
REQ-004 The block SHALL have port `busy`: output, 1 bit, high while a conversion is in progress.
REQ-005 The block SHALL have port `done`: output, 1 bit, one-cycle pulse marking a new result.
REQ-006 The block SHALL have port `overflow`: output, 1 bit, high when the last captured `value` exceeded 9999.
REQ-007 The block SHALL have ports `num3`, `num2`, `num1`, `num0`: outputs, 4 bits each, BCD digits (thousands, hundreds, tens, units) that feed the digit multiplexer.
REQ-008 The block SHALL have port `lz`: output, 4 bits, leading-zero mask; bit i set means digit i is a leading zero; bit 0 is always 0.

Function
REQ-009 The block SHALL implement the states IDLE, SHIFT and DONE.
REQ-010 In IDLE with `start`=1 at edge E0, the block SHALL capture `value`, clear the BCD accumulator and the iteration counter, enter SHIFT and set `busy`=1.
REQ-011 In SHIFT, on each of edges E1..E14, the block SHALL perform one double-dabble iteration: add 3 to each BCD nibble that is ≥5, then shift the {BCD, binary} register left by 1.
REQ-012 After the 14th iteration, the block SHALL enter DONE.
REQ-013 At edge E15, the block SHALL register the results to `num3..num0`, `lz` and `overflow`, drive `done`=1 for exactly one cycle and `busy`=0, and return to IDLE.
REQ-014 Latency SHALL be 15 cycles from start acceptance to `done`; a `start` sampled at E16 SHALL be accepted, giving a throughput of one conversion per 16 cycles.
REQ-015 `start` SHALL be ignored whenever the state is not IDLE; it SHALL NOT queue, restart or extend a conversion.
REQ-016 Changes to `value` after E0 SHALL NOT affect the result in progress.
REQ-017 If the captured `value` is >9999 (range 10000..16383), the block SHALL set `num3..num0`=9,9,9,9, `overflow`=1 and `lz`=0000.
REQ-018 For captured `value` ≤9999, the block SHALL set `overflow`=0.
REQ-019 `lz[3]` SHALL be 1 iff `num3`=0.
REQ-020 `lz[2]` SHALL be 1 iff `lz[3]`=1 and `num2`=0.
REQ-021 `lz[1]` SHALL be 1 iff `lz[2]`=1 and `num1`=0.
REQ-022 `lz[0]` SHALL be 0 for every result.
REQ-023 `num3..num0`, `lz` and `overflow` SHALL hold their values between `done` pulses; intermediate SHIFT values SHALL never appear on them.
REQ-024 Every BCD output SHALL be in the range 0..9 at all times.
REQ-025 `done` and `busy` SHALL never be high in the same cycle.

Reset
REQ-026 When `reset_n`=0 at a rising edge, the block SHALL enter IDLE and drive `busy`=0, `done`=0, `overflow`=0, `num3..num0`=0 and `lz`=1110.
REQ-027 A reset during SHIFT or DONE SHALL abort the conversion with no `done` pulse.
REQ-028 The first `start` sampled with `reset_n`=1 after reset SHALL be accepted normally.
REQ-029 If `start`=1 coincides with `reset_n`=0, reset SHALL win and the request SHALL be dropped.

Verification
REQ-030 Scenario, reset: hold `reset_n`=0 for 3 edges → `busy`=0, `done`=0, `num3..0`=0,0,0,0, `lz`=1110, `overflow`=0.
REQ-031 Scenario, nominal conversion: `value`=1234 with a `start` pulse → `done` at E15 only, `num3..0`=1,2,3,4, `lz`=0000, `overflow`=0, `busy` high from E0 to E14.
REQ-032 Scenario, small values: `value`=0 → 0,0,0,0 with `lz`=1110; `value`=7 → 0,0,0,7 with `lz`=1110; `value`=305 → 0,3,0,5 with `lz`=1000.
REQ-033 Scenario, limits: `value`=9999 → 9,9,9,9 with `overflow`=0; `value`=10000 → 9,9,9,9 with `overflow`=1; `value`=16383 → 9,9,9,9 with `overflow`=1.
REQ-034 Scenario, ignored input: `start` held high for 20 cycles while `value` changes 1234→5678 at E3 → first result 1,2,3,4 at E15; second conversion accepted at E16 yields 5,6,7,8 at E31.
REQ-035 Scenario, reset mid-operation: `reset_n`=0 at E7 of a conversion of 4321 → no `done`, outputs at reset values; next conversion of 42 → 0,0,4,2 with `lz`=1100.
